bcd_seven_seg_display: RTL and testbench

//  Downstream display stage for the sequence/counter generators on the EPM240 board.

---
 rtl/display_pkg.sv | 37 +++
 rtl/bcd_seven_seg_display_if.sv | 20 ++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/bcd_seven_seg_display.sv | 81 ++++++++
 tb/tb_bcd_seven_seg_display.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : display_pkg                                                     |
// | Brief    : Shared FSM states and active-low 7-segment decode table.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit 7 is the decimal point and stays off (1) in every code.
    function automatic logic [7:0] seg7_digit(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seven_seg_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_seven_seg_display_if                                        |
// | Brief    : Value handshake and display outputs of the 7-segment stage.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface bcd_seven_seg_display_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [7:0]        seg;
    logic [DIGITS-1:0] dig;

    modport master (output in_valid, output in_data, input in_ready, input seg, input dig);
    modport slave  (input in_valid, input in_data, output in_ready, output seg, output dig);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bin2bcd_seq                                                     |
// | Brief    : Handshaked sequential double-dabble, one input bit per clock.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                in_valid,
    input  wire logic [DATA_W-1:0]   in_data,
    output logic                     in_ready,
    output logic [4*DIGITS-1:0]      bcd,
    output logic                     done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                     state;
    state_t                     state_next;
    logic [DATA_W-1:0]          bin_sr;
    logic [CNT_W-1:0]           bit_cnt;
    logic [4*DIGITS-1:0]        bcd_adj;
    logic [4*DIGITS+DATA_W-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CONV;
            CONV:    if (bit_cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign done     = (state == DONE);

    // Add-3 correction so each nibble carries correctly after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {bcd_adj, bin_sr} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr  <= in_data;
                        bcd     <= '0;
                        bit_cnt <= CNT_W'(DATA_W);
                    end
                end
                CONV: begin
                    {bcd, bin_sr} <= shifted;
                    bit_cnt       <= bit_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_seven_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_seven_seg_display                                           |
// | Brief    : Binary value to multiplexed active-low decimal 7-seg display.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bcd_seven_seg_display
    import display_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIGITS     = 3,
    parameter int SCAN_DIV_W = 16
) (
    input wire logic                 clk,
    input wire logic                 rst,
    bcd_seven_seg_display_if.slave   bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] conv_bcd;
    logic                conv_done;
    logic [4*DIGITS-1:0] disp;
    logic [SCAN_DIV_W-1:0] presc;
    logic [IDX_W-1:0]    scan_idx;
    logic [DIGITS-1:0]   blank_vec;
    logic [3:0]          cur_nib;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_data  (bus.in_data),
        .in_ready (bus.in_ready),
        .bcd      (conv_bcd),
        .done     (conv_done)
    );

    // Shown value changes only on a completed conversion.
    always_ff @(posedge clk) begin
        if (rst)            disp <= '0;
        else if (conv_done) disp <= conv_bcd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (presc == {SCAN_DIV_W{1'b1}}) begin
                if (scan_idx == IDX_W'(DIGITS - 1)) scan_idx <= '0;
                else                                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_blank
        if (k == 0) begin : g_units
            assign blank_vec[k] = 1'b0;
        end else begin : g_upper
            assign blank_vec[k] = (disp[4*DIGITS-1:4*k] == '0);
        end
    end

    assign cur_nib = disp[{scan_idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.seg <= SEG_BLANK;
            bus.dig <= '1;
        end else begin
            bus.seg <= blank_vec[scan_idx] ? SEG_BLANK : seg7_digit(cur_nib);
            bus.dig <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_seven_seg_display                                        |
// | Brief    : Scoreboard bench with decimal reference model for the display.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_bcd_seven_seg_display;
    localparam int DATA_W     = 8;
    localparam int DIGITS     = 3;
    localparam int SCAN_DIV_W = 2;
    localparam int WINDOW     = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_q[$];

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    bcd_seven_seg_display_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

    bcd_seven_seg_display #(
        .DATA_W     (DATA_W),
        .DIGITS     (DIGITS),
        .SCAN_DIV_W (SCAN_DIV_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Decimal digit k of value, blank when value has fewer than k+1 digits.
    function automatic logic [7:0] ref_seg(input int value, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k > 0 && value < p) return 8'hFF;
        return seg_tab[(value / p) % 10];
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic send(input int v);
        int lowcnt;
        int guard;
        @(negedge clk);
        bus.in_data  = DATA_W'(v);
        bus.in_valid = 1'b1;
        exp_q.push_back(v);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check(1'b0, "accept_timeout", guard, 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            lowcnt++;
        end
        check(lowcnt == DATA_W + 1, $sformatf("busy_len_%0d", v), lowcnt, DATA_W + 1);
    endtask

    // Monitor: each return of in_ready marks a display update; check one scan window.
    initial begin : monitor
        logic prev;
        logic rise;
        int   win;
        int   exp_v;
        int   idx;
        bit   seen [DIGITS];
        bit   all_seen;
        prev  = 1'b1;
        win   = -1;
        exp_v = 0;
        forever begin
            @(negedge clk);
            rise = (bus.in_ready === 1'b1) && (prev === 1'b0);
            prev = bus.in_ready;
            if (rise) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_update", 1, 0);
                    win = -1;
                end else begin
                    exp_v = exp_q.pop_front();
                    win   = 0;
                    foreach (seen[k]) seen[k] = 1'b0;
                end
            end else if (win >= 0) begin
                if (rst === 1'b0 && bus.dig !== '1) begin
                    idx = -1;
                    for (int k = 0; k < DIGITS; k++)
                        if (bus.dig === ~(DIGITS'(1) << k)) idx = k;
                    if (idx < 0) begin
                        check(1'b0, "dig_onehot", int'(bus.dig), 0);
                    end else begin
                        seen[idx] = 1'b1;
                        check(bus.seg === ref_seg(exp_v, idx),
                              $sformatf("seg_val%0d_dig%0d", exp_v, idx),
                              int'(bus.seg), int'(ref_seg(exp_v, idx)));
                    end
                end
                win++;
                if (win == WINDOW) begin
                    all_seen = 1'b1;
                    foreach (seen[k]) all_seen &= seen[k];
                    check(all_seen, $sformatf("scan_cover_%0d", exp_v), int'(all_seen), 1);
                    win = -1;
                end
            end
        end
    end

    initial begin : stimulus
        logic [DIGITS-1:0] d;
        logic [DIGITS-1:0] prev_d;
        int run;
        bit first_run;
        int cnt;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(bus.in_ready === 1'b1, "reset_ready", int'(bus.in_ready), 1);

        // Idle after reset: '0' on units, upper digits blank, 4-clk scan rotation.
        prev_d    = '1;
        run       = 0;
        first_run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = bus.dig;
            check((d == 3'b110 && bus.seg == 8'hC0) ||
                  ((d == 3'b101 || d == 3'b011) && bus.seg == 8'hFF),
                  "reset_digit", int'({d, bus.seg}), 0);
            if (i > 0 && d != prev_d) begin
                check(d == {prev_d[1:0], prev_d[2]}, "scan_order", int'(d), int'({prev_d[1:0], prev_d[2]}));
                if (!first_run) check(run == 4, "scan_period", run, 4);
                first_run = 1'b0;
                run = 1;
            end else begin
                run++;
            end
            prev_d = d;
        end

        send(233);
        repeat (WINDOW + 3) @(posedge clk);
        send(8);
        repeat (WINDOW + 3) @(posedge clk);
        send(100);
        repeat (WINDOW + 3) @(posedge clk);

        // 255 accepted, then 13 held valid throughout the conversion.
        @(negedge clk);
        bus.in_data  = 8'd255;
        bus.in_valid = 1'b1;
        exp_q.push_back(255);
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1 bus.in_data = 8'd13;
        exp_q.push_back(13);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.in_ready === 1'b1) break;
        end
        check(cnt == DATA_W + 2, "held_accept_delay", cnt, DATA_W + 2);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (DATA_W + WINDOW + 5) @(posedge clk);

        // Reset in the middle of converting 144.
        @(negedge clk);
        bus.in_data  = 8'd144;
        bus.in_valid = 1'b1;
        cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(bus.in_ready === 1'b1, "ready_after_abort", int'(bus.in_ready), 1);
        repeat (WINDOW + 3) @(posedge clk);

        for (int v = 0; v < 256; v++) begin
            send(v);
            repeat (WINDOW + 3) @(posedge clk);
        end

        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 255)));
            repeat ($urandom_range(WINDOW + 3, WINDOW + 12)) @(posedge clk);
        end

        repeat (40) @(posedge clk);
        check(exp_q.size() == 0, "queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
